// File: rtl/che_cdf_map_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | che_cdf_map_seq_pkg                                                      |
// | Shared defaults and FSM state encoding for the sequential CDF-map kernel |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package che_cdf_map_seq_pkg;

    localparam int GRAY_LVL_DEF  = 256;
    localparam int PIX_WD_DEF    = 8;
    localparam int BIN_WD_DEF    = 13;
    localparam int TILE_LOG2_DEF = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_BUILD = 2'd2,
        ST_MAP   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/che_cdf_lut.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | che_cdf_lut                                                              |
// | Mapping LUT: one synchronous write port, one combinational read port     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module che_cdf_lut #(
    parameter int DEPTH = 256,
    parameter int WD    = 8,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [WD-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [WD-1:0] o_rdata
);

    logic [WD-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/che_cdf_map_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | che_cdf_map_seq                                                          |
// | Serial histogram -> sequential CDF -> LUT -> pixel remap, all streamed.  |
// | Optional clip-limit redistribution with macro CHE_CDF_CLIP_EN.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module che_cdf_map_seq
    import che_cdf_map_seq_pkg::*;
#(
    parameter int GRAY_LVL  = GRAY_LVL_DEF,
    parameter int PIX_WD    = PIX_WD_DEF,
    parameter int BIN_WD    = BIN_WD_DEF,
    parameter int TILE_LOG2 = TILE_LOG2_DEF,
    parameter int CDF_WD    = TILE_LOG2 + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hist_vld_i,
    input  logic [BIN_WD-1:0] hist_dat_i,
    output logic              hist_rdy_o,
`ifdef CHE_CDF_CLIP_EN
    input  logic [BIN_WD-1:0] clip_lmt_i,
`endif
    input  logic              pix_vld_i,
    input  logic [PIX_WD-1:0] pix_dat_i,
    input  logic              pix_last_i,
    output logic              pix_rdy_o,
    output logic              pix_vld_o,
    output logic [PIX_WD-1:0] pix_dat_o,
    output logic              pix_last_o,
    input  logic              pix_rdy_i,
    output logic              busy_o
);

    localparam int CNT_WD  = PIX_WD + 1;
    localparam int ACC_WD  = ((CDF_WD > BIN_WD) ? CDF_WD : BIN_WD) + 2;
    localparam int PROD_WD = CDF_WD + PIX_WD;
    localparam logic [ACC_WD-1:0]  c_tile_pix = ACC_WD'(1) << TILE_LOG2;
    localparam logic [PROD_WD-1:0] c_half     = PROD_WD'(1) << (TILE_LOG2 - 1);
    localparam logic [PROD_WD-1:0] c_lvl_max  = PROD_WD'(GRAY_LVL - 1);

    state_t              r_state, w_state_nxt;
    logic [CNT_WD-1:0]   r_cnt;
    logic [CDF_WD-1:0]   r_cdf;
    logic [BIN_WD-1:0]   r_hist [GRAY_LVL];
    logic                r_vld_o, r_last_o;
    logic [PIX_WD-1:0]   r_dat_o;

    logic                w_hist_acc, w_pix_acc, w_last_bin, w_lut_we;
    logic [BIN_WD-1:0]   w_bin_st, w_hist_rd;
    logic [CDF_WD-1:0]   w_incr, w_cdf_nxt;
    logic [ACC_WD-1:0]   w_cdf_sum;
    logic [PROD_WD-1:0]  w_scaled;
    logic [PIX_WD-1:0]   w_lut_wdata, w_lut_rd;

    assign w_hist_acc = hist_vld_i && ((r_state == ST_IDLE) || (r_state == ST_LOAD));
    assign w_pix_acc  = pix_vld_i && (r_state == ST_MAP) && (!r_vld_o || pix_rdy_i);
    assign w_last_bin = (r_cnt == CNT_WD'(GRAY_LVL - 1));

`ifdef CHE_CDF_CLIP_EN
    localparam logic [ACC_WD-1:0] c_excess_max = (ACC_WD'(1) << CDF_WD) - ACC_WD'(1);

    logic [BIN_WD-1:0] r_clip, w_clip, w_over;
    logic [CDF_WD-1:0] r_excess, w_excess_base;
    logic [ACC_WD-1:0] w_excess_sum;

    // The clip limit is live on the first beat and held for the rest of the tile.
    assign w_clip        = (r_state == ST_IDLE) ? clip_lmt_i : r_clip;
    assign w_excess_base = (r_state == ST_IDLE) ? '0 : r_excess;
    assign w_excess_sum  = ACC_WD'(w_excess_base) + ACC_WD'(w_over);
    assign w_incr        = r_excess >> PIX_WD;

    always_comb begin
        w_bin_st = hist_dat_i;
        w_over   = '0;
        if ((w_clip != '0) && (hist_dat_i > w_clip)) begin
            w_bin_st = w_clip;
            w_over   = hist_dat_i - w_clip;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_excess <= '0;
            r_clip   <= '0;
        end else if (w_hist_acc) begin
            if (r_state == ST_IDLE) begin
                r_clip <= clip_lmt_i;
            end
            r_excess <= (w_excess_sum > c_excess_max) ? c_excess_max[CDF_WD-1:0]
                                                      : w_excess_sum[CDF_WD-1:0];
        end
    end
`else
    assign w_bin_st = hist_dat_i;
    assign w_incr   = '0;
`endif

    // CDF step and scaling; the cdf is clamped so an over-full histogram never wraps.
    assign w_hist_rd   = r_hist[r_cnt[PIX_WD-1:0]];
    assign w_cdf_sum   = ACC_WD'(r_cdf) + ACC_WD'(w_hist_rd) + ACC_WD'(w_incr);
    assign w_cdf_nxt   = (w_cdf_sum > c_tile_pix) ? c_tile_pix[CDF_WD-1:0] : w_cdf_sum[CDF_WD-1:0];
    assign w_scaled    = (PROD_WD'(w_cdf_nxt) * c_lvl_max + c_half) >> TILE_LOG2;
    assign w_lut_wdata = (w_scaled > c_lvl_max) ? c_lvl_max[PIX_WD-1:0] : w_scaled[PIX_WD-1:0];
    assign w_lut_we    = (r_state == ST_BUILD) && !r_cnt[PIX_WD];

    che_cdf_lut #(
        .DEPTH (GRAY_LVL),
        .WD    (PIX_WD),
        .AW    (PIX_WD)
    ) u_lut (
        .clk     (clk),
        .i_we    (w_lut_we),
        .i_waddr (r_cnt[PIX_WD-1:0]),
        .i_wdata (w_lut_wdata),
        .i_raddr (pix_dat_i),
        .o_rdata (w_lut_rd)
    );

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_hist_acc) w_state_nxt = ST_LOAD;
            ST_LOAD:  if (w_hist_acc && w_last_bin) w_state_nxt = ST_BUILD;
            ST_BUILD: if (r_cnt[PIX_WD]) w_state_nxt = ST_MAP;
            ST_MAP:   if (w_pix_acc && pix_last_i) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // BUILD runs one extra cycle (cnt == GRAY_LVL) with no write before MAP.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_cdf   <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    r_cdf <= '0;
                    if (w_hist_acc) r_cnt <= r_cnt + CNT_WD'(1);
                end
                ST_LOAD: begin
                    if (w_hist_acc) r_cnt <= w_last_bin ? '0 : r_cnt + CNT_WD'(1);
                end
                ST_BUILD: begin
                    r_cdf <= w_cdf_nxt;
                    r_cnt <= r_cnt[PIX_WD] ? '0 : r_cnt + CNT_WD'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_hist_acc) begin
            r_hist[r_cnt[PIX_WD-1:0]] <= w_bin_st;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_o  <= 1'b0;
            r_dat_o  <= '0;
            r_last_o <= 1'b0;
        end else if (w_pix_acc) begin
            r_vld_o  <= 1'b1;
            r_dat_o  <= w_lut_rd;
            r_last_o <= pix_last_i;
        end else if (pix_rdy_i) begin
            r_vld_o  <= 1'b0;
        end
    end

    assign hist_rdy_o = (r_state == ST_IDLE) || (r_state == ST_LOAD);
    assign pix_rdy_o  = (r_state == ST_MAP) && (!r_vld_o || pix_rdy_i);
    assign busy_o     = (r_state != ST_IDLE);
    assign pix_vld_o  = r_vld_o;
    assign pix_dat_o  = r_dat_o;
    assign pix_last_o = r_last_o;

endmodule
`default_nettype wire

// File: tb/tb_che_cdf_map_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_che_cdf_map_seq                                                       |
// | Randomized self-checking bench against an arithmetic CLAHE LUT model.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_che_cdf_map_seq;

    localparam int GRAY_LVL  = 256;
    localparam int PIX_WD    = 8;
    localparam int BIN_WD    = 13;
    localparam int TILE_LOG2 = 12;
    localparam int TILE_PIX  = 1 << TILE_LOG2;
    localparam int EXC_MAX   = (1 << (TILE_LOG2 + 1)) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              hist_vld_i;
    logic [BIN_WD-1:0] hist_dat_i;
    logic              hist_rdy_o;
    logic [BIN_WD-1:0] clip_lmt_i;
    logic              pix_vld_i;
    logic [PIX_WD-1:0] pix_dat_i;
    logic              pix_last_i;
    logic              pix_rdy_o;
    logic              pix_vld_o;
    logic [PIX_WD-1:0] pix_dat_o;
    logic              pix_last_o;
    logic              pix_rdy_i;
    logic              busy_o;

    int     n_checks = 0;
    int     n_fail   = 0;
    int     tile_h  [GRAY_LVL];
    int     exp_lut [GRAY_LVL];
    int     clip_val;
    int     px_q [$];
    longint t_first;

    always #5 clk = ~clk;

    che_cdf_map_seq dut (
        .clk        (clk),
        .rst        (rst),
        .hist_vld_i (hist_vld_i),
        .hist_dat_i (hist_dat_i),
        .hist_rdy_o (hist_rdy_o),
`ifdef CHE_CDF_CLIP_EN
        .clip_lmt_i (clip_lmt_i),
`endif
        .pix_vld_i  (pix_vld_i),
        .pix_dat_i  (pix_dat_i),
        .pix_last_i (pix_last_i),
        .pix_rdy_o  (pix_rdy_o),
        .pix_vld_o  (pix_vld_o),
        .pix_dat_o  (pix_dat_o),
        .pix_last_o (pix_last_o),
        .pix_rdy_i  (pix_rdy_i),
        .busy_o     (busy_o)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: clip, spread the excess evenly, accumulate, clamp, scale with rounding.
    task automatic model_lut();
        int stored [GRAY_LVL];
        int excess = 0;
        int incr;
        int cdf = 0;
        int v;
        for (int k = 0; k < GRAY_LVL; k++) begin
            stored[k] = tile_h[k];
`ifdef CHE_CDF_CLIP_EN
            if (clip_val != 0 && tile_h[k] > clip_val) begin
                stored[k] = clip_val;
                excess    = excess + (tile_h[k] - clip_val);
                if (excess > EXC_MAX) excess = EXC_MAX;
            end
`endif
        end
        incr = excess / GRAY_LVL;
        for (int k = 0; k < GRAY_LVL; k++) begin
            cdf = cdf + stored[k] + incr;
            if (cdf > TILE_PIX) cdf = TILE_PIX;
            v = (cdf * (GRAY_LVL - 1) + TILE_PIX / 2) / TILE_PIX;
            exp_lut[k] = (v > GRAY_LVL - 1) ? GRAY_LVL - 1 : v;
        end
    endtask

    task automatic send_hist(input bit bubbles);
        int g;
        for (int i = 0; i < GRAY_LVL; i++) begin
            if (bubbles) begin
                while ($urandom_range(3) == 0) begin
                    hist_vld_i = 1'b0;
                    tick();
                end
            end
            hist_vld_i = 1'b1;
            hist_dat_i = BIN_WD'(tile_h[i]);
            clip_lmt_i = BIN_WD'(clip_val);
            if (i == 0) t_first = $time;
            g = 0;
            while (!hist_rdy_o && g < 2000) begin
                tick();
                g++;
            end
            check("hist_rdy", hist_rdy_o, 1);
            check("pix_rdy_in_load", pix_rdy_o, 0);
            tick();
        end
        hist_vld_i = 1'b0;
    endtask

    task automatic wait_map();
        int g = 0;
        while (!pix_rdy_o && g < 3000) begin
            tick();
            g++;
        end
        check("map_reached", pix_rdy_o, 1);
    endtask

    // mode 0: no stalls, 1: ready toggles every cycle, 2: random valid/ready
    task automatic run_pixels(input int mode);
        int n = px_q.size();
        int idx = 0;
        int got = 0;
        int g = 0;
        int ed_q [$];
        bit el_q [$];
        while (got < n && g < 4000) begin
            pix_vld_i  = (idx < n) && (mode != 2 || $urandom_range(3) != 0);
            pix_dat_i  = (idx < n) ? PIX_WD'(px_q[idx]) : '0;
            pix_last_i = (idx == n - 1);
            pix_rdy_i  = (mode == 0) ? 1'b1 : (mode == 1) ? (g % 2 == 0) : 1'($urandom_range(1));
            @(negedge clk);
            if (pix_vld_o) begin
                if (ed_q.size() == 0) begin
                    check("spurious_vld", pix_vld_o, 0);
                end else begin
                    if (pix_rdy_i) check("pix_dat", pix_dat_o, ed_q[0]);
                    else           check("pix_dat_stall", pix_dat_o, ed_q[0]);
                    check("pix_last", pix_last_o, el_q[0]);
                    if (pix_rdy_i) begin
                        void'(ed_q.pop_front());
                        void'(el_q.pop_front());
                        got++;
                    end
                end
            end
            if (pix_vld_i && pix_rdy_o) begin
                ed_q.push_back(exp_lut[px_q[idx]]);
                el_q.push_back(idx == n - 1);
                idx++;
            end
            tick();
            g++;
        end
        pix_vld_i  = 1'b0;
        pix_last_i = 1'b0;
        pix_rdy_i  = 1'b1;
        check("pix_count", got, n);
        @(negedge clk);
        check("drained_vld", pix_vld_o, 0);
        check("busy_after_last", busy_o, 0);
        tick();
    endtask

    task automatic fill_tile(input int v);
        for (int k = 0; k < GRAY_LVL; k++) tile_h[k] = v;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; hist_vld_i = 1'b0; hist_dat_i = '0; clip_lmt_i = '0;
        pix_vld_i = 1'b0; pix_dat_i = '0; pix_last_i = 1'b0; pix_rdy_i = 1'b1;
        clip_val = 0;
        repeat (3) tick();
        check("rst_hist_rdy", hist_rdy_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_pix_rdy", pix_rdy_o, 0);
        check("rst_pix_vld", pix_vld_o, 0);
        check("rst_pix_dat", pix_dat_o, 0);
        check("rst_pix_last", pix_last_o, 0);
        rst = 1'b0;
        tick();

        // Flat histogram with LUT-ready latency
        fill_tile(16);
        model_lut();
        send_hist(1'b0);
        wait_map();
        check("lut_latency", ($time - t_first) / 10, 2 * GRAY_LVL + 1);
        px_q = '{0, 127, 255};
        run_pixels(0);

        // Single spike, no clip
        fill_tile(0);
        tile_h[100] = 4096;
        model_lut();
        send_hist(1'b1);
        wait_map();
        px_q = '{0, 99, 100, 255};
        run_pixels(0);

`ifdef CHE_CDF_CLIP_EN
        clip_val = 64;
        model_lut();
        send_hist(1'b0);
        wait_map();
        px_q = '{99, 100, 255};
        run_pixels(0);
        clip_val = 0;
`endif

        // Backpressure on a 4-pixel burst
        for (int k = 0; k < GRAY_LVL; k++) tile_h[k] = $urandom_range(0, 31);
        model_lut();
        send_hist(1'b1);
        wait_map();
        px_q.delete();
        for (int i = 0; i < 4; i++) px_q.push_back($urandom_range(0, GRAY_LVL - 1));
        run_pixels(1);

        // Over-full histogram; first abort a MAP with a pending output
        fill_tile(8191);
        model_lut();
        send_hist(1'b0);
        wait_map();
        pix_rdy_i = 1'b0; pix_vld_i = 1'b1; pix_dat_i = 8'd5; pix_last_i = 1'b0;
        tick();
        pix_vld_i = 1'b0;
        check("pend_vld", pix_vld_o, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pix_rdy_i = 1'b1;
        check("rst_map_vld", pix_vld_o, 0);
        check("rst_map_busy", busy_o, 0);
        send_hist(1'b1);
        wait_map();
        px_q.delete();
        for (int i = 0; i < 8; i++) px_q.push_back($urandom_range(0, GRAY_LVL - 1));
        run_pixels(2);

        // Reset during BUILD, then a clean flat tile
        fill_tile(16);
        model_lut();
        send_hist(1'b0);
        repeat (50) tick();
        check("build_busy", busy_o, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_build_busy", busy_o, 0);
        check("rst_build_hist_rdy", hist_rdy_o, 1);
        check("rst_build_pix_vld", pix_vld_o, 0);
        send_hist(1'b0);
        wait_map();
        px_q = '{0, 127, 255};
        run_pixels(0);

        // Random tiles with random clip (when built in), bubbles and stalls
        for (int t = 0; t < 3; t++) begin
            for (int k = 0; k < GRAY_LVL; k++) tile_h[k] = $urandom_range(0, 40);
            tile_h[$urandom_range(0, GRAY_LVL - 1)] = $urandom_range(0, 2000);
`ifdef CHE_CDF_CLIP_EN
            clip_val = $urandom_range(0, 40);
`endif
            model_lut();
            send_hist(1'b1);
            wait_map();
            px_q.delete();
            for (int i = 0; i < 24; i++) px_q.push_back($urandom_range(0, GRAY_LVL - 1));
            run_pixels(2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
